// File: rtl/alu_share_arbiter_pkg.sv
// Shared encodings for the shared-ALU arbiter: FSM states, ALU_Control codes
// and the trace tap record.
package alu_share_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Low three bits follow funct3; bits [5:3] select the class (010 = branch compare)
    localparam logic [5:0] ALU_ADD  = 6'b000_000;
    localparam logic [5:0] ALU_SLL  = 6'b000_001;
    localparam logic [5:0] ALU_SLT  = 6'b000_010;
    localparam logic [5:0] ALU_SLTU = 6'b000_011;
    localparam logic [5:0] ALU_XOR  = 6'b000_100;
    localparam logic [5:0] ALU_SRL  = 6'b000_101;
    localparam logic [5:0] ALU_OR   = 6'b000_110;
    localparam logic [5:0] ALU_AND  = 6'b000_111;
    localparam logic [5:0] ALU_SUB  = 6'b001_000;
    localparam logic [5:0] ALU_SRA  = 6'b001_101;
    localparam logic [5:0] ALU_BEQ  = 6'b010_000;
    localparam logic [5:0] ALU_BNE  = 6'b010_001;
    localparam logic [5:0] ALU_BLT  = 6'b010_100;
    localparam logic [5:0] ALU_BGE  = 6'b010_101;
    localparam logic [5:0] ALU_BLTU = 6'b010_110;
    localparam logic [5:0] ALU_BGEU = 6'b010_111;

    localparam logic [2:0] CLASS_BRANCH = 3'b010;

    typedef struct packed {
        logic        en;
        logic [31:0] cycle;
        logic [7:0]  core;
        state_t      state;
        logic        grant;
        logic [5:0]  ctrl;
    } trace_t;

    function automatic logic is_branch(input logic [5:0] ctrl);
        return ctrl[5:3] == CLASS_BRANCH;
    endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Two valid/ready request channels plus one tagged response channel.
interface alu_share_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  req0_valid;
    logic                  req0_ready;
    logic [5:0]            req0_ctrl;
    logic [DATA_WIDTH-1:0] req0_a;
    logic [DATA_WIDTH-1:0] req0_b;
    logic                  req1_valid;
    logic                  req1_ready;
    logic [5:0]            req1_ctrl;
    logic [DATA_WIDTH-1:0] req1_a;
    logic [DATA_WIDTH-1:0] req1_b;
    logic                  resp_valid;
    logic                  resp_id;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] resp_result;
    logic                  resp_zero;
    logic                  resp_branch;

    modport master (
        output req0_valid, req0_ctrl, req0_a, req0_b,
        output req1_valid, req1_ctrl, req1_a, req1_b,
        output resp_ready,
        input  req0_ready, req1_ready,
        input  resp_valid, resp_id, resp_result, resp_zero, resp_branch
    );

    modport slave (
        input  req0_valid, req0_ctrl, req0_a, req0_b,
        input  req1_valid, req1_ctrl, req1_a, req1_b,
        input  resp_ready,
        output req0_ready, req1_ready,
        output resp_valid, resp_id, resp_result, resp_zero, resp_branch
    );
endinterface

// File: rtl/alu_share_arbiter_alu.sv
// Combinational ALU decoding 6-bit ALU_Control codes; branch compares yield 0/1.
module alu_share_arbiter_alu
    import alu_share_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [5:0]            ctrl_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  zero_o,
    output logic                  branch_o
);
    localparam int SHW = $clog2(DATA_WIDTH);

    logic [SHW-1:0] shamt;
    logic           lt_s;
    logic           lt_u;

    assign shamt = b_i[SHW-1:0];
    assign lt_s  = $signed(a_i) < $signed(b_i);
    assign lt_u  = a_i < b_i;

    always_comb begin
        result_o = '0;
        case (ctrl_i)
            ALU_ADD:  result_o = a_i + b_i;
            ALU_SUB:  result_o = a_i - b_i;
            ALU_SLL:  result_o = a_i << shamt;
            ALU_SRL:  result_o = a_i >> shamt;
            ALU_SRA:  result_o = $signed(a_i) >>> shamt;
            ALU_SLT:  result_o = {{(DATA_WIDTH-1){1'b0}}, lt_s};
            ALU_SLTU: result_o = {{(DATA_WIDTH-1){1'b0}}, lt_u};
            ALU_XOR:  result_o = a_i ^ b_i;
            ALU_OR:   result_o = a_i | b_i;
            ALU_AND:  result_o = a_i & b_i;
            ALU_BEQ:  result_o = {{(DATA_WIDTH-1){1'b0}}, a_i == b_i};
            ALU_BNE:  result_o = {{(DATA_WIDTH-1){1'b0}}, a_i != b_i};
            ALU_BLT:  result_o = {{(DATA_WIDTH-1){1'b0}}, lt_s};
            ALU_BGE:  result_o = {{(DATA_WIDTH-1){1'b0}}, !lt_s};
            ALU_BLTU: result_o = {{(DATA_WIDTH-1){1'b0}}, lt_u};
            ALU_BGEU: result_o = {{(DATA_WIDTH-1){1'b0}}, !lt_u};
            default:  result_o = '0;
        endcase
    end

    assign zero_o   = result_o == '0;
    assign branch_o = is_branch(ctrl_i) && (result_o == DATA_WIDTH'(1));

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one ALU between two requesters; one op in flight,
// registered tagged response held until the owner takes it.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int CORE       = 0,
    parameter int DATA_WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    alu_share_arbiter_if.slave   bus,
    output logic                 busy,
    input  logic                 report,
    output trace_t               trace_o
);
    state_t                state_q, state_d;
    logic                  last_grant_q;
    logic                  lat_id_q;
    logic [5:0]            ctrl_q;
    logic [DATA_WIDTH-1:0] a_q, b_q;
    logic                  resp_valid_q, resp_id_q, zero_q, branch_q;
    logic [DATA_WIDTH-1:0] result_q;
    logic [31:0]           cyc_q;

    logic                  grant, ready0, ready1, accept;
    logic [DATA_WIDTH-1:0] alu_res;
    logic                  alu_zero, alu_branch;

    // On a tie the requester that did not win last time goes first
    always_comb begin
        grant = bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid)
            grant = !last_grant_q;
    end

    assign ready0 = (state_q == IDLE) && !grant && bus.req0_valid;
    assign ready1 = (state_q == IDLE) &&  grant && bus.req1_valid;
    assign accept = ready0 || ready1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (bus.resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_grant_q <= 1'b1;
            lat_id_q     <= 1'b0;
            ctrl_q       <= '0;
            a_q          <= '0;
            b_q          <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= 1'b0;
            result_q     <= '0;
            zero_q       <= 1'b0;
            branch_q     <= 1'b0;
            cyc_q        <= '0;
        end else begin
            cyc_q <= cyc_q + 32'd1;
            case (state_q)
                IDLE: if (accept) begin
                    ctrl_q       <= grant ? bus.req1_ctrl : bus.req0_ctrl;
                    a_q          <= grant ? bus.req1_a    : bus.req0_a;
                    b_q          <= grant ? bus.req1_b    : bus.req0_b;
                    lat_id_q     <= grant;
                    last_grant_q <= grant;
                end
                EXEC: begin
                    result_q     <= alu_res;
                    zero_q       <= alu_zero;
                    branch_q     <= alu_branch;
                    resp_id_q    <= lat_id_q;
                    resp_valid_q <= 1'b1;
                end
                RESP: if (bus.resp_ready) resp_valid_q <= 1'b0;
                default: ;
            endcase
        end
    end

    alu_share_arbiter_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
        .ctrl_i   (ctrl_q),
        .a_i      (a_q),
        .b_i      (b_q),
        .result_o (alu_res),
        .zero_o   (alu_zero),
        .branch_o (alu_branch)
    );

    assign bus.req0_ready  = ready0;
    assign bus.req1_ready  = ready1;
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_id     = resp_id_q;
    assign bus.resp_result = result_q;
    assign bus.resp_zero   = zero_q;
    assign bus.resp_branch = branch_q;
    assign busy            = state_q != IDLE;

    // Trace tap: the consumer prints a line whenever en is set
    always_comb begin
        trace_o       = '0;
        trace_o.en    = report;
        trace_o.cycle = cyc_q;
        trace_o.core  = 8'(CORE);
        trace_o.state = state_q;
        trace_o.grant = grant;
        trace_o.ctrl  = ctrl_q;
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with hand-computed expected responses.
module tb_alu_share_arbiter;
    import alu_share_arbiter_pkg::*;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    logic   busy;
    logic   report = 1'b0;
    trace_t trace;
    int     n_chk = 0;
    int     n_fail = 0;

    alu_share_arbiter_if #(.DATA_WIDTH(32)) bus ();

    alu_share_arbiter #(.CORE(0), .DATA_WIDTH(32)) dut (
        .clock   (clk),
        .reset   (rst_n),
        .bus     (bus),
        .busy    (busy),
        .report  (report),
        .trace_o (trace)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (trace.en)
            $display("[core%0d cyc %0d] st=%0d grant=%0d ctrl=%b rv=%b id=%0d res=%h",
                     trace.core, trace.cycle, trace.state, trace.grant, trace.ctrl,
                     bus.resp_valid, bus.resp_id, bus.resp_result);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called at a sample point with the FSM idle and resp_ready high
    task automatic do_op(input string tag, input bit idx, input logic [5:0] c,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic ez, input logic eb);
        if (idx) begin
            bus.req1_valid = 1'b1; bus.req1_ctrl = c; bus.req1_a = a; bus.req1_b = b;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_ctrl = c; bus.req0_a = a; bus.req0_b = b;
        end
        #1;
        chk({tag, "_rdy"}, {bus.req1_ready, bus.req0_ready}, idx ? 2'b10 : 2'b01);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        chk({tag, "_exec"}, {busy, bus.resp_valid}, 2'b10);
        @(posedge clk); #1;
        chk({tag, "_rv"},  bus.resp_valid, 1'b1);
        chk({tag, "_id"},  bus.resp_id, idx);
        chk({tag, "_res"}, bus.resp_result, er);
        chk({tag, "_zb"},  {bus.resp_zero, bus.resp_branch}, {ez, eb});
        @(posedge clk); #1;
        chk({tag, "_done"}, {busy, bus.resp_valid}, 2'b00);
    endtask

    initial begin
        int waited;
        bus.req0_valid = 0; bus.req0_ctrl = 0; bus.req0_a = 0; bus.req0_b = 0;
        bus.req1_valid = 0; bus.req1_ctrl = 0; bus.req1_a = 0; bus.req1_b = 0;
        bus.resp_ready = 1'b1;

        @(posedge clk); #1;
        chk("rst_rv",   bus.resp_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_res",  {bus.resp_result, bus.resp_id, bus.resp_zero, bus.resp_branch}, 35'd0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        report = 1'b1;
        do_op("add0", 1'b0, ALU_ADD, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0);
        report = 1'b0;
        do_op("sub1", 1'b1, ALU_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0);

        // Both requesters saturating: grants must alternate 0,1,0,1
        bus.req0_ctrl = ALU_ADD; bus.req0_a = 32'd1;  bus.req0_b = 32'd2;
        bus.req1_ctrl = ALU_SUB; bus.req1_a = 32'd10; bus.req1_b = 32'd3;
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            waited = 0;
            while (!(bus.req0_ready || bus.req1_ready) && waited < 10) begin
                @(posedge clk); #1;
                waited++;
            end
            chk("fair_wait",  waited < 10, 1'b1);
            chk("fair_grant", {bus.req1_ready, bus.req0_ready}, (k % 2) ? 2'b10 : 2'b01);
            @(posedge clk); #1;
            chk("fair_exrdy", {bus.req1_ready, bus.req0_ready}, 2'b00);
            @(posedge clk); #1;
            chk("fair_rv",  bus.resp_valid, 1'b1);
            chk("fair_id",  bus.resp_id, k % 2);
            chk("fair_res", bus.resp_result, (k % 2) ? 32'd7 : 32'd3);
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        @(posedge clk); #1;

        do_op("beq", 1'b0, ALU_BEQ, 32'h1234, 32'h1234, 32'd1, 1'b0, 1'b1);
        do_op("bne", 1'b0, ALU_BNE, 32'h1234, 32'h1234, 32'd0, 1'b1, 1'b0);
        do_op("unk", 1'b1, 6'b111_111, 32'd9, 32'd9, 32'd0, 1'b1, 1'b0);
        do_op("slt", 1'b0, ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0);

        // Backpressure: response must hold while resp_ready is low
        bus.resp_ready = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_ctrl = ALU_AND; bus.req0_a = 32'hF0F0; bus.req0_b = 32'hFF00;
        #1;
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b1; bus.req1_ctrl = ALU_ADD; bus.req1_a = 32'd1; bus.req1_b = 32'd1;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_rv",   {bus.resp_valid, busy, bus.resp_id}, 3'b110);
            chk("bp_res",  {bus.resp_result, bus.resp_zero, bus.resp_branch}, {32'h0000_F000, 2'b00});
            chk("bp_rdy",  {bus.req1_ready, bus.req0_ready}, 2'b00);
            @(posedge clk); #1;
        end
        bus.req1_valid = 1'b0;
        bus.resp_ready = 1'b1;
        #1;
        chk("bp_hs_rdy", {bus.req1_ready, bus.req0_ready}, 2'b00);
        @(posedge clk); #1;
        chk("bp_release", {bus.resp_valid, busy}, 2'b00);

        do_op("sra", 1'b1, ALU_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 1'b0);

        // Reset in EXEC after a req0 accept; req0 must still win the next tie
        bus.req0_valid = 1'b1; bus.req0_ctrl = ALU_ADD; bus.req0_a = 32'd3; bus.req0_b = 32'd4;
        #1;
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        chk("ar_exec", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_rv",   {bus.resp_valid, busy}, 2'b00);
        chk("ar_outs", {bus.resp_result, bus.resp_id, bus.resp_zero, bus.resp_branch}, 35'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        bus.req0_ctrl = ALU_OR;  bus.req0_a = 32'h00F0; bus.req0_b = 32'h0F00;
        bus.req1_ctrl = ALU_XOR; bus.req1_a = 32'h1;    bus.req1_b = 32'h1;
        #1;
        chk("ar_tie", {bus.req1_ready, bus.req0_ready}, 2'b01);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        @(posedge clk); #1;
        chk("ar_resp", {bus.resp_valid, bus.resp_id, bus.resp_result}, {1'b1, 1'b0, 32'h0FF0});

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
